// File: rtl/crc9_pkg.sv
// Shared constants, state encoding and the single-bit CRC-9 step used by the
// frame controller and its three-bit update slice.
`timescale 1ns/1ps
package crc9_pkg;

    localparam int             CRC_W        = 9;
    localparam logic [CRC_W-1:0] POLY       = 9'h103;
    localparam int             BITS_PER_CYC = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // MSB-first, non-reflected LFSR step for x^9+x^8+x+1.
    function automatic logic [CRC_W-1:0] crcBitStep(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

endpackage

// File: rtl/crc9_step3.sv
// Combinational CRC-9 update that consumes three message bits per call,
// oldest bit in bits[2].
`timescale 1ns/1ps
module crc9_step3
    import crc9_pkg::*;
(
    input  logic [CRC_W-1:0]        crc,
    input  logic [BITS_PER_CYC-1:0] bits,
    output logic [CRC_W-1:0]        crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
            crc_next = crcBitStep(crc_next, bits[i]);
        end
    end

endmodule

// File: rtl/crc9_frame_ctrl.sv
// Frame-level CRC-9 controller: accepts 9-bit words, folds three bits per clock
// into the CRC and holds the finished frame CRC until the consumer takes it.
`timescale 1ns/1ps
module crc9_frame_ctrl
    import crc9_pkg::*;
#(
    parameter logic [CRC_W-1:0] CRC_INIT = 9'h000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             msg_valid,
    input  logic [CRC_W-1:0] msg_data,
    input  logic             msg_last,
    output logic             msg_ready,
    input  logic             abort,
    output logic             crc_valid,
    input  logic             crc_ready,
    output logic [CRC_W-1:0] crc_out,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_mid;
    logic             r_last;
    logic [1:0]       r_phase;
    logic [CRC_W-1:0] r_sr;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] r_crcOut;
    logic [7:0]       r_frameCnt;
    logic [CRC_W-1:0] w_crcNext;
    logic             w_handshake;
    logic             w_phaseEnd;

    crc9_step3 u_step3 (
        .crc      (r_crc),
        .bits     (r_sr[CRC_W-1 -: BITS_PER_CYC]),
        .crc_next (w_crcNext)
    );

    assign w_phaseEnd  = (r_state == ST_SHIFT) && (r_phase == 2'd2);
    assign w_handshake = msg_valid && msg_ready;
    assign crc_out     = r_crcOut;
    assign frame_cnt   = r_frameCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (abort) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_handshake) w_stateNext = ST_SHIFT;
                ST_SHIFT: begin
                    if (w_phaseEnd) begin
                        if (w_handshake)  w_stateNext = ST_SHIFT;
                        else if (r_last)  w_stateNext = ST_DONE;
                        else              w_stateNext = ST_IDLE;
                    end
                end
                ST_DONE:  if (crc_ready) w_stateNext = ST_IDLE;
                default:  w_stateNext = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        msg_ready = !reset && !abort && ((r_state == ST_IDLE) || (w_phaseEnd && !r_last));
        busy      = !reset && (r_state != ST_IDLE);
        crc_valid = (r_state == ST_DONE);
    end

    // The last triplet of a word and the next word load share one edge, so a
    // phase-2 handshake overrides the shift of sr/last/phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mid      <= 1'b0;
            r_phase    <= 2'd0;
            r_sr       <= '0;
            r_last     <= 1'b0;
            r_crc      <= CRC_INIT;
            r_crcOut   <= '0;
            r_frameCnt <= 8'd0;
        end else if (abort) begin
            r_mid <= 1'b0;
            r_crc <= CRC_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_sr    <= msg_data;
                        r_last  <= msg_last;
                        r_phase <= 2'd0;
                        if (!r_mid) r_crc <= CRC_INIT;
                    end
                end
                ST_SHIFT: begin
                    r_crc   <= w_crcNext;
                    r_sr    <= {r_sr[CRC_W-BITS_PER_CYC-1:0], {BITS_PER_CYC{1'b0}}};
                    r_phase <= w_phaseEnd ? 2'd0 : r_phase + 2'd1;
                    if (w_phaseEnd) begin
                        if (w_handshake) begin
                            r_sr   <= msg_data;
                            r_last <= msg_last;
                        end else if (r_last) begin
                            r_crcOut <= w_crcNext;
                        end else begin
                            r_mid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (crc_ready) begin
                        r_mid      <= 1'b0;
                        r_frameCnt <= r_frameCnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc9_frame_ctrl.sv
// Directed bench for crc9_frame_ctrl: expected CRCs are queued when a frame is
// sent and popped when crc_valid appears.
`timescale 1ns/1ps
module tb_crc9_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       msg_valid;
    logic [8:0] msg_data;
    logic       msg_last;
    logic       msg_ready;
    logic       abort;
    logic       crc_valid;
    logic       crc_ready;
    logic [8:0] crc_out;
    logic       busy;
    logic [7:0] frame_cnt;

    int         checks = 0;
    int         errors = 0;
    int         expCnt = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    crc9_frame_ctrl #(.CRC_INIT(9'h000)) dut (
        .clk       (clk),
        .reset     (reset),
        .msg_valid (msg_valid),
        .msg_data  (msg_data),
        .msg_last  (msg_last),
        .msg_ready (msg_ready),
        .abort     (abort),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready),
        .crc_out   (crc_out),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // Bit-serial reference, one word MSB first.
    function automatic logic [8:0] modelWord(input logic [8:0] c, input logic [8:0] w);
        logic fb;
        for (int i = 8; i >= 0; i--) begin
            fb = c[8] ^ w[i];
            c  = {c[7:0], 1'b0};
            if (fb) c = c ^ 9'h103;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] d, input logic l, output longint acc);
        int n;
        n         = 0;
        acc       = 0;
        msg_valid = 1'b1;
        msg_data  = d;
        msg_last  = l;
        #0;
        while (!msg_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("accept", {31'd0, msg_ready}, 32'd1);
        if (msg_ready) begin
            @(posedge clk);
            acc = $time;
            #1;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int         n;
        logic [8:0] exp;
        n = 0;
        while (!crc_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, {31'd0, crc_valid}, 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
        checkOutput(tag, {23'd0, crc_out}, {23'd0, exp});
    endtask

    task automatic releaseResult(input string tag);
        crc_ready = 1'b1;
        tick();
        crc_ready = 1'b0;
        expCnt    = (expCnt + 1) % 256;
        checkOutput({tag, "_cnt"}, {24'd0, frame_cnt}, expCnt);
        checkOutput({tag, "_vld_lo"}, {31'd0, crc_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint t1, t2;
        logic [8:0] w1, w2, c;

        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_data  = '0;
        msg_last  = 1'b0;
        abort     = 1'b0;
        crc_ready = 1'b0;
        repeat (3) tick();
        checkOutput("rst_ready", {31'd0, msg_ready}, 32'd0);
        checkOutput("rst_busy",  {31'd0, busy},      32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_valid", {31'd0, crc_valid}, 32'd0);
        checkOutput("rst_out",   {23'd0, crc_out},   32'd0);
        checkOutput("rst_cnt",   {24'd0, frame_cnt}, 32'd0);
        checkOutput("idle_ready", {31'd0, msg_ready}, 32'd1);

        // Single word 0x001: latency of exactly three edges.
        sb.push_back(9'h103);
        applyStimulus(9'h001, 1'b1, t1);
        checkOutput("lat_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        checkOutput("lat_early", {31'd0, crc_valid}, 32'd0);
        tick();
        checkOutput("lat_t3", {31'd0, crc_valid}, 32'd1);
        waitResult("w001");
        releaseResult("w001");

        sb.push_back(9'h002);
        applyStimulus(9'h100, 1'b1, t1);
        waitResult("w100");
        releaseResult("w100");

        // Back-to-back two-word frame.
        sb.push_back(9'h006);
        applyStimulus(9'h001, 1'b0, t1);
        applyStimulus(9'h100, 1'b1, t2);
        checkOutput("b2b_gap", 32'((t2 - t1) / 10), 32'd3);
        waitResult("b2b");
        releaseResult("b2b");

        // Same frame with a wait between the words.
        sb.push_back(9'h006);
        applyStimulus(9'h001, 1'b0, t1);
        repeat (8) tick();
        checkOutput("gap_busy",  {31'd0, busy},      32'd0);
        checkOutput("gap_ready", {31'd0, msg_ready}, 32'd1);
        checkOutput("gap_valid", {31'd0, crc_valid}, 32'd0);
        applyStimulus(9'h100, 1'b1, t2);
        waitResult("gap");
        releaseResult("gap");

        // Result held in DONE, then dropped by abort.
        sb.push_back(9'h002);
        applyStimulus(9'h100, 1'b1, t1);
        waitResult("hold");
        msg_valid = 1'b1;
        msg_data  = 9'h0F0;
        msg_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold_out",   {23'd0, crc_out},   32'h002);
            checkOutput("hold_ready", {31'd0, msg_ready}, 32'd0);
        end
        msg_valid = 1'b0;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        #1;
        checkOutput("abort_valid", {31'd0, crc_valid}, 32'd0);
        checkOutput("abort_busy",  {31'd0, busy},      32'd0);
        checkOutput("abort_cnt",   {24'd0, frame_cnt}, expCnt);

        // Abort alongside an offered word in IDLE.
        abort     = 1'b1;
        msg_valid = 1'b1;
        msg_data  = 9'h001;
        msg_last  = 1'b1;
        #1;
        checkOutput("abort_noacc", {31'd0, msg_ready}, 32'd0);
        tick();
        abort     = 1'b0;
        msg_valid = 1'b0;
        #1;
        checkOutput("abort_idle", {31'd0, busy}, 32'd0);
        sb.push_back(9'h103);
        applyStimulus(9'h001, 1'b1, t1);
        waitResult("post_abort");
        releaseResult("post_abort");

        // Abort during a multi-word frame must restart the CRC.
        applyStimulus(9'h0AA, 1'b0, t1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        checkOutput("midabort_busy", {31'd0, busy}, 32'd0);
        sb.push_back(9'h103);
        applyStimulus(9'h001, 1'b1, t1);
        waitResult("midabort");
        releaseResult("midabort");

        // Random frames up to the frame counter wrap.
        while (expCnt != 0) begin
            w1 = 9'($urandom_range(0, 511));
            w2 = 9'($urandom_range(0, 511));
            c  = modelWord(9'h000, w1);
            if ($urandom_range(0, 1) == 1) begin
                sb.push_back(modelWord(c, w2));
                applyStimulus(w1, 1'b0, t1);
                applyStimulus(w2, 1'b1, t2);
            end else begin
                sb.push_back(c);
                applyStimulus(w1, 1'b1, t1);
            end
            waitResult("rand");
            releaseResult("rand");
        end
        checkOutput("wrap_cnt", {24'd0, frame_cnt}, 32'd0);

        // Reset in the middle of a frame.
        applyStimulus(9'h055, 1'b0, t1);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("rstmid_ready", {31'd0, msg_ready}, 32'd0);
        checkOutput("rstmid_busy",  {31'd0, busy},      32'd0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rstmid_cnt", {24'd0, frame_cnt}, 32'd0);
        checkOutput("rstmid_out", {23'd0, crc_out},   32'd0);
        checkOutput("rstmid_idle", {31'd0, busy},     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc9_frame_ctrl.md
CRC9_FRAME_CTRL -- requirements
Module: crc9_frame_ctrl

Interface
REQ-001 SHALL have parameter CRC_INIT, default 9'h000: CRC register value at frame start.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port msg_valid, input, 1: a message word is offered.
REQ-005 SHALL have port msg_data, input, 9: message word, transmitted MSB (bit 8) first.
REQ-006 SHALL have port msg_last, input, 1: the offered word ends the frame.
REQ-007 SHALL have port msg_ready, output, 1: the block accepts the word this cycle.
REQ-008 SHALL have port abort, input, 1: discard the current frame.
REQ-009 SHALL have port crc_valid, output, 1: crc_out holds a finished frame CRC.
REQ-010 SHALL have port crc_ready, input, 1: the consumer takes crc_out.
REQ-011 SHALL have port crc_out, output, 9: the frame CRC.
REQ-012 SHALL have port busy, output, 1: high when the state is not IDLE.
REQ-013 SHALL have port frame_cnt, output, 8: number of completed frames, wrapping 255 -> 0.

Function
REQ-014 CRC definition, fixed: generator x^9+x^8+x+1 (POLY = 9'h103), init CRC_INIT, no reflection, no final XOR.
REQ-015 Serial bit step, fixed: fb = c[8]^b; c = {c[7:0],0} ^ (fb ? POLY : 0).
REQ-016 Each cycle in SHIFT SHALL apply three serial steps, bits taken in order sr[8], sr[7], sr[6]; then sr SHALL shift left by 3.
REQ-017 States: IDLE, SHIFT, DONE; phase counter 0..2 is valid only in SHIFT.
REQ-018 msg_ready SHALL equal !reset && !abort && (IDLE || (SHIFT && phase==2 && !last_q)).
REQ-019 On a handshake (msg_valid && msg_ready):
- sr <= msg_data; last_q <= msg_last; phase <= 0; state <= SHIFT.
- If this is a frame start from IDLE, the CRC register SHALL be loaded with CRC_INIT.
REQ-020 In SHIFT, at each edge: CRC updates per REQ-016; phase increments.
- At phase==2 with no handshake, the next state SHALL be DONE if last_q, else IDLE-hold-frame (wait for the next word, CRC retained; msg_ready=1).
REQ-021 Mid-frame wait SHALL be encoded as state IDLE with flag mid_q=1. A handshake from IDLE with mid_q=1 SHALL NOT reload CRC_INIT.
REQ-022 Back-to-back words SHALL sustain one word per 3 cycles: the final triplet update and the next word load occur on the same edge.
REQ-023 Latency: a single-word frame accepted at edge T SHALL present crc_valid=1 after edge T+3.
REQ-024 In DONE:
- crc_valid=1; crc_out is stable; msg_ready=0.
- On crc_valid && crc_ready: state <= IDLE; mid_q <= 0; frame_cnt++ (modulo 256); crc_valid <= 0.
REQ-025 crc_out SHALL equal the CRC register while in DONE and SHALL hold its last value otherwise.
REQ-026 abort, when high, SHALL take priority over all handshakes:
- state <= IDLE; mid_q <= 0; crc_valid <= 0; CRC register <= CRC_INIT.
- frame_cnt SHALL be unchanged.
- A pending DONE result SHALL be dropped.
REQ-027 abort in IDLE with no frame in progress SHALL have no visible effect.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set:
- state IDLE, mid_q 0, phase 0, sr 0, last_q 0;
- CRC register CRC_INIT, crc_out 0, crc_valid 0, frame_cnt 0.
REQ-029 Outputs during reset: msg_ready=0 and busy=0. Reset mid-frame SHALL discard the frame without incrementing frame_cnt.

Structure
REQ-030 Package crc9_pkg SHALL hold CRC_W=9, POLY=9'h103, BITS_PER_CYC=3, and the state enum.
REQ-031 Sub-module crc9_step3 SHALL contain the combinational 3-bit update (inputs crc[8:0], bits[2:0]; output crc_next[8:0]); the controller instantiates it once.

Verification
REQ-032 Single-word frame 9'h001 (last=1), CRC_INIT=0 -> crc_valid rises 3 cycles after accept; crc_out=9'h103.
REQ-033 Single-word frame 9'h100 -> crc_out=9'h002.
REQ-034 Two-word back-to-back frame 9'h001 then 9'h100 (last) -> second accept exactly 3 cycles after the first; crc_out=9'h006; frame_cnt=1 after crc_ready.
REQ-035 Same two-word frame with a 5-cycle gap between words -> crc_out=9'h006 (CRC retained through the mid-frame wait).
REQ-036 crc_ready held low for 10 cycles in DONE -> crc_out stable and msg_ready=0 throughout; then abort pulse -> IDLE, crc_valid=0, frame_cnt unchanged.
REQ-037 Abort asserted in the same cycle as msg_valid in IDLE -> no accept (msg_ready=0); next frame 9'h001 -> crc_out=9'h103; 256 completed frames -> frame_cnt wraps to 0.
